// File: rtl/core_seq.sv
// SIMD accumulator core: broadcast commands update a local accumulator, and a
// selected core can stream its accumulator or operand buffer out over the RAM bus.
module core_seq #(
   parameter int unsigned CORE_ID = 0,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned RAM_W   = 16,
   parameter int unsigned ID_W    = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] input_i,
   input  logic [RAM_W-1:0]  ram_i,
   input  logic              ram_wr_i,
   input  logic              sel_save_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [2:0]        cmd_op_i,
   input  logic [1:0]        cmd_src_i,
   input  logic              rd_start_i,
   input  logic              rd_src_i,
   output logic [RAM_W-1:0]  ram_o,
   output logic              ram_oe_o,
   output logic              selected_o,
   output logic              busy_o
);

   localparam int unsigned WORDS = DATA_W / RAM_W;
   localparam int unsigned CNT_W = $clog2(WORDS + 1);
   localparam int unsigned SH_W  = $clog2(DATA_W);
   localparam int unsigned PC_W  = $clog2(DATA_W + 1);

   localparam logic [2:0] OP_NOP0   = 3'd0;
   localparam logic [2:0] OP_LOAD   = 3'd1;
   localparam logic [2:0] OP_XOR    = 3'd2;
   localparam logic [2:0] OP_ADD    = 3'd3;
   localparam logic [2:0] OP_ROTL   = 3'd4;
   localparam logic [2:0] OP_POPCNT = 3'd5;
   localparam logic [2:0] OP_MIN    = 3'd6;

   localparam logic [1:0] SRC_INPUT = 2'd0;
   localparam logic [1:0] SRC_ID    = 2'd1;
   localparam logic [1:0] SRC_BUF   = 2'd2;

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic              busy_q, busy_d;

   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] alu_res;
   logic [PC_W-1:0]   pop_cnt;
   logic [SH_W-1:0]   rot_amt;
   logic              cmd_acc;
   logic              rd_acc;
   logic              sel_match;

   logic [ID_W-1:0]   sel_id;
   logic [ID_W-1:0]   sel_mask;

   assign sel_id    = input_i[ID_W-1:0];
   assign sel_mask  = input_i[2*ID_W-1:ID_W];
   // Mask bits set to 1 exclude that id bit from the comparison.
   assign sel_match = (((sel_id ^ ID_W'(CORE_ID)) & ~sel_mask) == '0);

   assign cmd_ready_o = rst_ni & ~busy_q;
   assign cmd_acc     = cmd_valid_i & cmd_ready_o;
   assign rd_acc      = rd_start_i & sel_q & ~busy_q;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      src = acc_q;
      unique case (cmd_src_i)
         SRC_INPUT: src = input_i;
         SRC_ID:    src = DATA_W'(CORE_ID);
         SRC_BUF:   src = buf_q;
         default:   src = acc_q;
      endcase
   end

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         pop_cnt = pop_cnt + PC_W'(acc_q[i]);
      end
   end

   assign rot_amt = src[SH_W-1:0];

   always_comb begin
      alu_res = acc_q;
      unique case (cmd_op_i)
         OP_LOAD:   alu_res = src;
         OP_XOR:    alu_res = acc_q ^ src;
         OP_ADD:    alu_res = acc_q + src;
         // A right shift by the full width yields zero, so rot_amt=0 is exact.
         OP_ROTL:   alu_res = (acc_q << rot_amt) | (acc_q >> (DATA_W - int'(rot_amt)));
         OP_POPCNT: alu_res = DATA_W'(pop_cnt);
         OP_MIN:    alu_res = (src < acc_q) ? src : acc_q;
         OP_NOP0:   alu_res = acc_q;
         default:   alu_res = acc_q;
      endcase
   end

   always_comb begin
      acc_d  = acc_q;
      buf_d  = buf_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      sel_d  = sel_q;
      busy_d = busy_q;

      if (cmd_acc) begin
         acc_d = alu_res;
      end

      if (ram_wr_i && sel_q && !busy_q) begin
         buf_d = {ram_i, buf_q[DATA_W-1:RAM_W]};
      end

      if (sel_save_i) begin
         sel_d = sel_match;
      end

      // The snapshot reads acc_q, so a command accepted on the same edge is
      // not yet visible in the readout.
      if (busy_q) begin
         rd_d   = rd_q >> RAM_W;
         cnt_d  = cnt_q - CNT_W'(1);
         busy_d = (cnt_q != CNT_W'(1));
      end else if (rd_acc) begin
         rd_d   = rd_src_i ? buf_q : acc_q;
         cnt_d  = CNT_W'(WORDS);
         busy_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         buf_q  <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         sel_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         buf_q  <= buf_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         busy_q <= busy_d;
      end
   end

   assign ram_oe_o   = busy_q;
   assign busy_o     = busy_q;
   assign selected_o = sel_q;
   assign ram_o      = busy_q ? rd_q[RAM_W-1:0] : '0;

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: a behavioural model predicts state, readout
// words are queued at readout start and compared as the core emits them.
module tb_core_seq;
   localparam int unsigned CORE_ID = 5;
   localparam int DW    = 64;
   localparam int RW    = 16;
   localparam int IW    = 24;
   localparam int WORDS = DW / RW;
   localparam int SHW   = $clog2(DW);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] inp;
   logic [RW-1:0] ram_in;
   logic          ram_wr, sel_save, cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [1:0]    cmd_src;
   logic          rd_start, rd_src;
   logic [RW-1:0] ram_out;
   logic          ram_oe, selected, busy;

   always #5 clk = ~clk;

   core_seq #(.CORE_ID(CORE_ID), .DATA_W(DW), .RAM_W(RW), .ID_W(IW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .input_i(inp), .ram_i(ram_in), .ram_wr_i(ram_wr),
      .sel_save_i(sel_save), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .rd_start_i(rd_start), .rd_src_i(rd_src),
      .ram_o(ram_out), .ram_oe_o(ram_oe), .selected_o(selected), .busy_o(busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [DW-1:0] m_acc, m_buf;
   logic          m_sel;
   int            m_left;
   logic          last_cmd_acc;
   logic [RW-1:0] sb_q[$];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [DW-1:0] model_op(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] s);
      logic [DW-1:0] r;
      logic [SHW-1:0] amt;
      r   = a;
      amt = s[SHW-1:0];
      case (op)
         3'd1: r = s;
         3'd2: r = a ^ s;
         3'd3: r = a + s;
         3'd4: for (int k = 0; k < int'(amt); k++) r = {r[DW-2:0], r[DW-1]};
         3'd5: r = DW'($countones(a));
         3'd6: r = (s < a) ? s : a;
         default: r = a;
      endcase
      return r;
   endfunction

   // One clock: predict the edge from the applied inputs, then compare outputs.
   task automatic tick();
      logic cmd_acc, rd_acc, wr_acc;
      logic [DW-1:0] src, snap, nacc;
      #1;
      check("cmd_ready", cmd_ready, rst_n && (m_left == 0));
      cmd_acc = cmd_valid && rst_n && (m_left == 0);
      rd_acc  = rd_start && m_sel && (m_left == 0);
      wr_acc  = ram_wr && m_sel && (m_left == 0);
      case (cmd_src)
         2'd0:    src = inp;
         2'd1:    src = DW'(CORE_ID);
         2'd2:    src = m_buf;
         default: src = m_acc;
      endcase
      nacc = cmd_acc ? model_op(cmd_op, m_acc, src) : m_acc;
      last_cmd_acc = cmd_acc;
      if (!rst_n) begin
         m_acc = '0; m_buf = '0; m_sel = 1'b0; m_left = 0;
         sb_q.delete();
      end else begin
         if (rd_acc) begin
            snap = rd_src ? m_buf : m_acc;
            for (int w = 0; w < WORDS; w++) sb_q.push_back(snap[w*RW +: RW]);
            m_left = WORDS;
         end else if (m_left > 0) begin
            m_left--;
         end
         if (wr_acc) m_buf = {ram_in, m_buf[DW-1:RW]};
         if (sel_save) m_sel = (((inp[IW-1:0] ^ IW'(CORE_ID)) & ~inp[2*IW-1:IW]) == '0);
         m_acc = nacc;
      end
      @(posedge clk);
      #1;
      check("selected", selected, m_sel);
      check("busy", busy, m_left > 0);
      check("ram_oe", ram_oe, m_left > 0);
      if (ram_oe) begin
         if (sb_q.size() > 0) check("ram_word", ram_out, sb_q.pop_front());
         else check("ram_word_unexpected", ram_oe, 1'b0);
      end else begin
         check("ram_idle_zero", ram_out, '0);
      end
   endtask

   task automatic idle();
      cmd_valid = 1'b0; rd_start = 1'b0; ram_wr = 1'b0; sel_save = 1'b0;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [1:0] s, input logic [DW-1:0] d);
      idle();
      cmd_valid = 1'b1; cmd_op = op; cmd_src = s; inp = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_sel(input logic [IW-1:0] id, input logic [IW-1:0] mask);
      idle();
      inp = (DW'(mask) << IW) | DW'(id);
      sel_save = 1'b1;
      tick();
      sel_save = 1'b0;
   endtask

   task automatic do_wr(input logic [RW-1:0] w);
      idle();
      ram_in = w; ram_wr = 1'b1;
      tick();
      ram_wr = 1'b0;
   endtask

   task automatic readout(input logic s);
      idle();
      rd_start = 1'b1; rd_src = s;
      tick();
      rd_start = 1'b0;
      repeat (WORDS + 1) tick();
   endtask

   initial begin
      logic done;
      m_acc = '0; m_buf = '0; m_sel = 1'b0; m_left = 0; last_cmd_acc = 1'b0;
      rst_n = 1'b0; inp = '0; ram_in = '0; cmd_op = '0; cmd_src = '0; rd_src = 1'b0;
      idle();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Selection with a don't-care mask bit, then exact match failing.
      do_sel(24'h000004, 24'h000001);
      do_sel(24'h000004, 24'h000000);
      readout(1'b0);                       // unselected: no words
      do_sel(24'hABCDEF, 24'hFFFFFF);      // all-ones mask selects

      // LOAD then ADD, read the accumulator.
      do_cmd(3'd1, 2'd0, 64'hFFFF_0000_0000_0001);
      do_cmd(3'd3, 2'd0, 64'h1);
      readout(1'b0);

      // Operand buffer fill, LOAD from buffer, POPCNT.
      do_wr(16'h1111); do_wr(16'h2222); do_wr(16'h3333); do_wr(16'h4444);
      readout(1'b1);
      do_cmd(3'd2, 2'd3, '0);              // XOR acc with itself clears it
      do_cmd(3'd1, 2'd2, '0);
      readout(1'b0);
      do_cmd(3'd5, 2'd0, '0);
      readout(1'b0);

      // Readout and command on the same edge, then a command stalled by busy.
      do_cmd(3'd1, 2'd1, '0);              // acc = CORE_ID
      idle();
      rd_start = 1'b1; rd_src = 1'b0;
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_src = 2'd0; inp = 64'h100;
      tick();
      rd_start = 1'b0;
      cmd_op = 3'd3; inp = 64'h2000;
      done = 1'b0;
      for (int i = 0; i < 16 && !done; i++) begin
         tick();
         done = last_cmd_acc;
      end
      idle();
      readout(1'b0);

      // Deselect during a readout does not abort it.
      idle();
      rd_start = 1'b1; rd_src = 1'b1;
      tick();
      rd_start = 1'b0;
      do_sel(24'h000004, 24'h000000);
      repeat (WORDS) tick();
      do_sel(24'h000005, 24'h000000);

      // rd_start during the last word is ignored.
      idle();
      rd_start = 1'b1; rd_src = 1'b0;
      tick();
      rd_start = 1'b0;
      repeat (WORDS - 1) tick();
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      repeat (2) tick();

      // Rotate and unsigned minimum.
      do_cmd(3'd1, 2'd0, 64'h10);
      do_cmd(3'd4, 2'd0, 64'd63);
      readout(1'b0);
      do_cmd(3'd6, 2'd0, 64'd3);
      readout(1'b0);
      do_cmd(3'd7, 2'd0, 64'hDEAD);        // NOP
      readout(1'b0);

      // Reset after two words of a readout.
      idle();
      rd_start = 1'b1; rd_src = 1'b0;
      tick();
      rd_start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (WORDS) tick();
      do_sel(24'h000005, 24'h000000);
      readout(1'b0);                       // accumulator cleared by reset

      check("sb_drained", DW'(sb_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
